// File: rtl/operand_reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_reg_file_pkg
// Description : Shared processor constants for the operand register file:
//               default geometry, register-index names, scoreboard state
//               encoding and an index range-check helper.
// Revision    : 1.0 - initial release
// ============================================================================
package operand_reg_file_pkg;

  localparam int c_DATA_W = 8;
  localparam int c_NREG   = 8;
  localparam int c_ADDR_W = $clog2(c_NREG);

  // Architectural register indices
  localparam int unsigned c_R0 = 0;
  localparam int unsigned c_R1 = 1;
  localparam int unsigned c_R2 = 2;
  localparam int unsigned c_R3 = 3;
  localparam int unsigned c_R4 = 4;
  localparam int unsigned c_R5 = 5;
  localparam int unsigned c_R6 = 6;
  localparam int unsigned c_R7 = 7;

  // Per-register scoreboard state
  typedef enum logic [0:0] {
    SB_IDLE    = 1'b0,
    SB_PENDING = 1'b1
  } sb_state_e;

  // True when a register index names an implemented register
  function automatic logic idx_valid(input int unsigned idx, input int unsigned nreg);
    return idx < nreg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_reg_file_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : One pending bit (two-state FSM) per register plus the
//               combinational operand-hazard (stall) detection.
// Ports       : clk_i/rst_i      - clock, async active-high reset
//               write_i/waddr_i  - write-back, clears pending of waddr_i
//               pend_set_i/pend_addr_i - multi-cycle producer issue
//               rdN_en_i/raddrN_i - read port use and index
//               bypassN_i        - write-back forwards to read port N
//               stall_o          - operand hazard
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
  import operand_reg_file_pkg::*;
#(
  parameter int NREG   = c_NREG,
  parameter int ADDR_W = c_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic              pend_set_i,
  input  logic [ADDR_W-1:0] pend_addr_i,
  input  logic              rd1_en_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic              bypass1_i,
  input  logic              rd2_en_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  input  logic              bypass2_i,
  output logic              stall_o
);

  sb_state_e state_q [NREG];
  sb_state_e state_d [NREG];

  logic pend1;
  logic pend2;
  logic stall;
  logic set_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        state_q[i] <= SB_IDLE;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    // Out-of-range indices match no entry and therefore never look pending
    for (int i = 0; i < NREG; i++) begin
      if (raddr1_i == ADDR_W'(i)) pend1 = (state_q[i] == SB_PENDING);
      if (raddr2_i == ADDR_W'(i)) pend2 = (state_q[i] == SB_PENDING);
    end
    stall  = ~rst_i & ((rd1_en_i & pend1 & ~bypass1_i) |
                       (rd2_en_i & pend2 & ~bypass2_i));
    // A producer issued while the stage is held has not really issued
    set_ok = pend_set_i & ~stall;
  end

  assign stall_o = stall;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        SB_IDLE: begin
          if (set_ok && pend_addr_i == ADDR_W'(i)) state_d[i] = SB_PENDING;
        end
        SB_PENDING: begin
          // A same-edge new producer to this index outranks the write-back
          if (write_i && waddr_i == ADDR_W'(i) &&
              !(set_ok && pend_addr_i == ADDR_W'(i))) state_d[i] = SB_IDLE;
        end
        default: state_d[i] = SB_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/operand_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : operand_reg_file
// Description : Two-read / one-write register file with write-back bypass
//               and a load-use scoreboard producing an issue stall.
// Ports       : CLK, RESET (async, active-high)
//               IN/INADDRESS/WRITE      - write-back port
//               OUT1ADDRESS/OUT2ADDRESS - combinational read indices
//               RD1_EN/RD2_EN           - read ports used by issuing instr
//               PEND_SET/PEND_ADDR      - multi-cycle producer issue
//               OUT1/OUT2               - operand data
//               STALL                   - operand hazard, stage holds
// Revision    : 1.0 - initial release
// ============================================================================
module operand_reg_file
  import operand_reg_file_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int NREG   = c_NREG,
  parameter int ADDR_W = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  input  logic              RD1_EN,
  input  logic              RD2_EN,
  input  logic              PEND_SET,
  input  logic [ADDR_W-1:0] PEND_ADDR,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              STALL
);

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];

  logic [DATA_W-1:0] rd1_data;
  logic [DATA_W-1:0] rd2_data;
  logic              wr_valid;
  logic              bypass1;
  logic              bypass2;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      rf_d[i] = rf_q[i];
      if (WRITE && INADDRESS == ADDR_W'(i)) rf_d[i] = IN;
    end
  end

  // Read mux defaults to zero so unimplemented indices read as 0
  always_comb begin
    rd1_data = '0;
    rd2_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (OUT1ADDRESS == ADDR_W'(i)) rd1_data = rf_q[i];
      if (OUT2ADDRESS == ADDR_W'(i)) rd2_data = rf_q[i];
    end
  end

  // Forwarding only applies to writes that actually land in a register
  assign wr_valid = WRITE & idx_valid(32'(INADDRESS), NREG);
  assign bypass1  = wr_valid & (INADDRESS == OUT1ADDRESS);
  assign bypass2  = wr_valid & (INADDRESS == OUT2ADDRESS);

  // Reset forces zero outputs even when a write-back would forward
  assign OUT1 = RESET ? '0 : (bypass1 ? IN : rd1_data);
  assign OUT2 = RESET ? '0 : (bypass2 ? IN : rd2_data);

  reg_scoreboard #(
    .NREG   (NREG),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .write_i     (WRITE),
    .waddr_i     (INADDRESS),
    .pend_set_i  (PEND_SET),
    .pend_addr_i (PEND_ADDR),
    .rd1_en_i    (RD1_EN),
    .raddr1_i    (OUT1ADDRESS),
    .bypass1_i   (bypass1),
    .rd2_en_i    (RD2_EN),
    .raddr2_i    (OUT2ADDRESS),
    .bypass2_i   (bypass2),
    .stall_o     (STALL)
  );

endmodule
`default_nettype wire

// File: tb/tb_operand_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_reg_file
// Description : Self-checking bench for operand_reg_file: directed vector
//               table, reset sequences and randomized traffic compared
//               against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_reg_file;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] IN;
  logic [2:0] INADDRESS;
  logic       WRITE;
  logic [2:0] OUT1ADDRESS;
  logic [2:0] OUT2ADDRESS;
  logic       RD1_EN;
  logic       RD2_EN;
  logic       PEND_SET;
  logic [2:0] PEND_ADDR;
  logic [7:0] OUT1;
  logic [7:0] OUT2;
  logic       STALL;

  int total = 0;
  int bad   = 0;

  operand_reg_file dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IN          (IN),
    .INADDRESS   (INADDRESS),
    .WRITE       (WRITE),
    .OUT1ADDRESS (OUT1ADDRESS),
    .OUT2ADDRESS (OUT2ADDRESS),
    .RD1_EN      (RD1_EN),
    .RD2_EN      (RD2_EN),
    .PEND_SET    (PEND_SET),
    .PEND_ADDR   (PEND_ADDR),
    .OUT1        (OUT1),
    .OUT2        (OUT2),
    .STALL       (STALL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       wr;
    logic [2:0] ia;
    logic [7:0] din;
    logic [2:0] a1;
    logic [2:0] a2;
    logic       r1;
    logic       r2;
    logic       ps;
    logic [2:0] pa;
    logic [7:0] e1;
    logic [7:0] e2;
    logic       es;
  } vec_t;

  vec_t tbl[$];

  // Reference model: register contents and set of pending registers
  logic [7:0] m_reg [8];
  bit         m_pend [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    WRITE       = v.wr;
    INADDRESS   = v.ia;
    IN          = v.din;
    OUT1ADDRESS = v.a1;
    OUT2ADDRESS = v.a2;
    RD1_EN      = v.r1;
    RD2_EN      = v.r2;
    PEND_SET    = v.ps;
    PEND_ADDR   = v.pa;
  endtask

  task automatic idle_inputs();
    WRITE = 0; INADDRESS = 0; IN = 0; OUT1ADDRESS = 0; OUT2ADDRESS = 0;
    RD1_EN = 0; RD2_EN = 0; PEND_SET = 0; PEND_ADDR = 0;
  endtask

  initial begin
    RESET = 1'b1;
    idle_inputs();

    //            wr ia din    a1 a2 r1 r2 ps pa  e1     e2     es
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0}); // reset state
    tbl.push_back('{1, 3, 8'h5A, 3, 3, 0, 0, 0, 0, 8'h5A, 8'h5A, 0}); // write r3, bypass both
    tbl.push_back('{0, 0, 8'h00, 3, 0, 1, 0, 0, 0, 8'h5A, 8'h00, 0}); // read back r3
    tbl.push_back('{1, 2, 8'h11, 3, 2, 0, 0, 0, 0, 8'h5A, 8'h11, 0}); // bypass on OUT2
    tbl.push_back('{0, 0, 8'h00, 2, 3, 0, 0, 0, 0, 8'h11, 8'h5A, 0}); // r2 stored
    tbl.push_back('{0, 0, 8'h00, 4, 3, 1, 0, 1, 4, 8'h00, 8'h5A, 0}); // issue load r4
    tbl.push_back('{0, 0, 8'h00, 4, 3, 1, 0, 0, 0, 8'h00, 8'h5A, 1}); // load-use hazard
    tbl.push_back('{1, 4, 8'h77, 4, 3, 1, 0, 0, 0, 8'h77, 8'h5A, 0}); // write-back bypass clears stall
    tbl.push_back('{0, 0, 8'h00, 4, 3, 1, 0, 0, 0, 8'h77, 8'h5A, 0}); // r4 no longer pending
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 1, 5, 8'h00, 8'h00, 0}); // issue load r5
    tbl.push_back('{1, 5, 8'h33, 0, 5, 0, 0, 1, 5, 8'h00, 8'h33, 0}); // collision on r5
    tbl.push_back('{0, 0, 8'h00, 0, 5, 0, 1, 0, 0, 8'h00, 8'h33, 1}); // r5 still pending
    tbl.push_back('{0, 0, 8'h00, 0, 5, 0, 1, 1, 6, 8'h00, 8'h33, 1}); // stalled issue of r6
    tbl.push_back('{0, 0, 8'h00, 6, 5, 1, 0, 0, 0, 8'h00, 8'h33, 0}); // r6 not pending

    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge CLK);
      chk($sformatf("vec%0d.OUT1", i), 32'(OUT1), 32'(tbl[i].e1));
      chk($sformatf("vec%0d.OUT2", i), 32'(OUT2), 32'(tbl[i].e2));
      chk($sformatf("vec%0d.STALL", i), 32'(STALL), 32'(tbl[i].es));
      @(posedge CLK);
      #1;
    end

    // Async reset pulse between edges
    idle_inputs();
    WRITE = 1; INADDRESS = 1; IN = 8'hFF; PEND_SET = 1; PEND_ADDR = 7;
    OUT1ADDRESS = 1; OUT2ADDRESS = 7; RD2_EN = 1;
    @(negedge CLK);
    chk("ar.pre_out1", 32'(OUT1), 32'hFF);
    @(posedge CLK);
    #1;
    WRITE = 0; PEND_SET = 0;
    #1 chk("ar.r7_stall", 32'(STALL), 32'd1);
    RESET = 1; WRITE = 1; INADDRESS = 1; IN = 8'hAA;
    #1;
    chk("ar.in_rst_out1", 32'(OUT1), 32'h0);
    chk("ar.in_rst_out2", 32'(OUT2), 32'h0);
    chk("ar.in_rst_stall", 32'(STALL), 32'h0);
    #1 RESET = 0; WRITE = 0;
    @(negedge CLK);
    chk("ar.post_out1", 32'(OUT1), 32'h0);
    chk("ar.post_stall", 32'(STALL), 32'h0);
    @(posedge CLK);
    #1;

    // Reset held across an edge: write and pend-set must be ignored
    RESET = 1; WRITE = 1; INADDRESS = 0; IN = 8'hC3; PEND_SET = 1; PEND_ADDR = 0;
    OUT1ADDRESS = 0; RD1_EN = 1; RD2_EN = 0;
    @(negedge CLK);
    chk("hr.in_rst_out1", 32'(OUT1), 32'h0);
    @(posedge CLK);
    #1 RESET = 0; WRITE = 0; PEND_SET = 0;
    @(negedge CLK);
    chk("hr.out1", 32'(OUT1), 32'h0);
    chk("hr.stall", 32'(STALL), 32'h0);
    @(posedge CLK);
    #1;

    // Randomized traffic against the reference model (state is clean here)
    for (int i = 0; i < 8; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
    for (int n = 0; n < 400; n++) begin
      logic [7:0] e1, e2;
      logic       es, b1, b2;
      WRITE       = ($urandom_range(2) == 0);
      INADDRESS   = 3'($urandom_range(7));
      IN          = 8'($urandom);
      OUT1ADDRESS = 3'($urandom_range(7));
      OUT2ADDRESS = 3'($urandom_range(7));
      RD1_EN      = 1'($urandom);
      RD2_EN      = 1'($urandom);
      PEND_SET    = ($urandom_range(2) == 0);
      PEND_ADDR   = 3'($urandom_range(7));
      b1 = WRITE && (INADDRESS == OUT1ADDRESS);
      b2 = WRITE && (INADDRESS == OUT2ADDRESS);
      e1 = b1 ? IN : m_reg[OUT1ADDRESS];
      e2 = b2 ? IN : m_reg[OUT2ADDRESS];
      es = (RD1_EN && m_pend[OUT1ADDRESS] && !b1) ||
           (RD2_EN && m_pend[OUT2ADDRESS] && !b2);
      @(negedge CLK);
      chk($sformatf("rnd%0d.OUT1", n), 32'(OUT1), 32'(e1));
      chk($sformatf("rnd%0d.OUT2", n), 32'(OUT2), 32'(e2));
      chk($sformatf("rnd%0d.STALL", n), 32'(STALL), 32'(es));
      @(posedge CLK);
      if (WRITE) begin
        m_reg[INADDRESS]  = IN;
        m_pend[INADDRESS] = 1'b0;
      end
      if (PEND_SET && !es) m_pend[PEND_ADDR] = 1'b1;
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
